// File: rtl/pong_renderer.sv
// Pong renderer: one-player paddle/ball game drawn on the VGA pixel stream.
// Optional feature macro SCORE_BAR_EN draws a red miss bar along the top edge.
module pong_renderer #(
   parameter logic [9:0] PADDLE_X     = 10'd16,
   parameter logic [9:0] PADDLE_W     = 10'd8,
   parameter logic [9:0] PADDLE_H     = 10'd64,
   parameter logic [9:0] PADDLE_SPEED = 10'd4,
   parameter logic [9:0] BALL_SIZE    = 10'd8,
   parameter logic [9:0] BALL_SPEED   = 10'd2,
   parameter logic [7:0] SERVE_FRAMES = 8'd60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] col,
   input  logic [9:0] row,
   input  logic       visible,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [5:0] rgb,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic [3:0] miss_count
);
   localparam logic [9:0] CX       = 10'd316;
   localparam logic [9:0] CY       = 10'd236;
   localparam logic [9:0] PY_MAX   = 10'd480 - PADDLE_H;
   localparam logic [9:0] BX_MAX   = 10'd640 - BALL_SIZE;
   localparam logic [9:0] BY_MAX   = 10'd480 - BALL_SIZE;
   localparam logic [9:0] BOUNCE_X = PADDLE_X + PADDLE_W;
   localparam logic [9:0] HIT_X_HI = PADDLE_X + PADDLE_W + BALL_SPEED;

   localparam logic [5:0] C_BALL   = 6'b111111;
   localparam logic [5:0] C_PADDLE = 6'b001100;
   localparam logic [5:0] C_BAR    = 6'b110000;
   localparam logic [5:0] C_BORDER = 6'b010101;
   localparam logic [5:0] C_BG     = 6'b000001;

   typedef enum logic {SERVE, PLAY} state_t;

   state_t     state, state_n;
   logic [9:0] py, py_n, bx, bx_n, by, by_n;
   logic       dx, dx_n, dy, dy_n;   // 1 = moving right / down
   logic [7:0] cnt, cnt_n;
   logic [3:0] miss_n;
   logic [1:0] up_sync, dn_sync;
   logic       up, dn, tick, hit, miss;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         up_sync <= 2'b00;
         dn_sync <= 2'b00;
      end else begin
         up_sync <= {up_sync[0], btn_up};
         dn_sync <= {dn_sync[0], btn_down};
      end
   end

   assign up   = up_sync[1];
   assign dn   = dn_sync[1];
   assign tick = (col == 10'd0) && (row == 10'd480);

   // Paddle test deliberately uses py from before this tick's move.
   assign hit = !dx && (bx <= HIT_X_HI) && (bx >= PADDLE_X) &&
                (by + BALL_SIZE > py) && (by < py + PADDLE_H);

   always_comb begin
      state_n = state;
      py_n    = py;
      bx_n    = bx;
      by_n    = by;
      dx_n    = dx;
      dy_n    = dy;
      cnt_n   = cnt;
      miss_n  = miss_count;
      miss    = 1'b0;
      if (tick) begin
         if (up && !dn)
            py_n = (py >= PADDLE_SPEED) ? py - PADDLE_SPEED : 10'd0;
         else if (dn && !up)
            py_n = (py >= PY_MAX - PADDLE_SPEED) ? PY_MAX : py + PADDLE_SPEED;
         case (state)
            SERVE: begin
               bx_n = CX;
               by_n = CY;
               if (cnt == SERVE_FRAMES - 8'd1) begin
                  cnt_n   = 8'd0;
                  state_n = PLAY;
                  dx_n    = 1'b1;
                  dy_n    = ~dy;
               end else begin
                  cnt_n = cnt + 8'd1;
               end
            end
            PLAY: begin
               if (dx) begin
                  if (bx + BALL_SIZE + BALL_SPEED >= 10'd640) begin
                     bx_n = BX_MAX;
                     dx_n = 1'b0;
                  end else begin
                     bx_n = bx + BALL_SPEED;
                  end
               end else if (hit) begin
                  bx_n = BOUNCE_X;
                  dx_n = 1'b1;
               end else if (bx < BALL_SPEED) begin
                  miss = 1'b1;
               end else begin
                  bx_n = bx - BALL_SPEED;
               end
               if (dy) begin
                  if (by + BALL_SIZE + BALL_SPEED >= 10'd480) begin
                     by_n = BY_MAX;
                     dy_n = 1'b0;
                  end else begin
                     by_n = by + BALL_SPEED;
                  end
               end else if (by < BALL_SPEED) begin
                  by_n = 10'd0;
                  dy_n = 1'b1;
               end else begin
                  by_n = by - BALL_SPEED;
               end
               // A miss overrides both axis results and re-centres the ball.
               if (miss) begin
                  miss_n  = (miss_count == 4'hF) ? 4'hF : miss_count + 4'd1;
                  state_n = SERVE;
                  bx_n    = CX;
                  by_n    = CY;
               end
            end
            default: state_n = SERVE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SERVE;
         py         <= 10'd208;
         bx         <= CX;
         by         <= CY;
         dx         <= 1'b1;
         dy         <= 1'b1;
         cnt        <= 8'd0;
         miss_count <= 4'd0;
      end else begin
         state      <= state_n;
         py         <= py_n;
         bx         <= bx_n;
         by         <= by_n;
         dx         <= dx_n;
         dy         <= dy_n;
         cnt        <= cnt_n;
         miss_count <= miss_n;
      end
   end

   logic       ball_px, pad_px, border_px, bar_px;
   logic [5:0] pix_rgb;

   assign ball_px = (col >= bx) && (col < bx + BALL_SIZE) &&
                    (row >= by) && (row < by + BALL_SIZE);
   assign pad_px  = (col >= PADDLE_X) && (col < PADDLE_X + PADDLE_W) &&
                    (row >= py) && (row < py + PADDLE_H);
   assign border_px = (col < 10'd4) || (col >= 10'd636) ||
                      (row < 10'd4) || (row >= 10'd476);

`ifdef SCORE_BAR_EN
   logic [9:0] bar_w;
   assign bar_w  = {2'b00, miss_count, 4'b0000};
   assign bar_px = (row < 10'd8) && (miss_count != 4'd0) && (col >= 10'd640 - bar_w);
`else
   assign bar_px = 1'b0;
`endif

   always_comb begin
      pix_rgb = C_BG;
      if (ball_px)        pix_rgb = C_BALL;
      else if (pad_px)    pix_rgb = C_PADDLE;
      else if (bar_px)    pix_rgb = C_BAR;
      else if (border_px) pix_rgb = C_BORDER;
   end

   // Syncs share the single register stage so they stay aligned with rgb.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb       <= 6'd0;
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
      end else begin
         rgb       <= visible ? pix_rgb : 6'd0;
         hsync_out <= hsync_in;
         vsync_out <= vsync_in;
      end
   end

endmodule

// File: doc/pong_renderer.md
Name: pong_renderer

Overview:
- Pixel-stage consumer of the VGA timing generator's col/row/visible/hsync/vsync outputs.
- Holds a one-player paddle-and-ball game state, updated once per frame during vertical blanking.
- Produces registered 6-bit RGB (2 bits per channel) and delay-matched sync signals for the board pins.
- Runs in the 25.125 MHz pixel clock domain.

Parameters:
PADDLE_X, 10'd16, left column of paddle
PADDLE_W, 10'd8, paddle width in pixels
PADDLE_H, 10'd64, paddle height in pixels
PADDLE_SPEED, 10'd4, paddle pixels moved per frame
BALL_SIZE, 10'd8, ball edge length (square)
BALL_SPEED, 10'd2, ball pixels per frame per axis
SERVE_FRAMES, 8'd60, frames held in SERVE before play resumes

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
col  input  10  current pixel column from timing generator
row  input  10  current pixel row from timing generator
visible  input  1  active-video flag
hsync_in  input  1  horizontal sync from timing generator, active-low
vsync_in  input  1  vertical sync from timing generator, active-low
btn_up  input  1  asynchronous push button, active-high
btn_down  input  1  asynchronous push button, active-high
rgb  output  6  {r[1:0],g[1:0],b[1:0]}, registered
hsync_out  output  1  hsync_in delayed 1 cycle
vsync_out  output  1  vsync_in delayed 1 cycle
miss_count  output  4  saturating miss counter

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is asynchronous and active-high. All flops are clk-posedge and async-cleared by reset.
- Reset values:
  - rgb=0, hsync_out=1, vsync_out=1, miss_count=0.
  - Paddle top py=208.
  - Ball bx=316, by=236; direction dx=+ (right), dy=+ (down).
  - State SERVE; serve counter=0.
- Buttons: each passes a 2-flop synchronizer before use. Synchronizer reset value is 0.
- Frame tick: a 1-cycle pulse when col==0 && row==480. Game state changes only on a tick.
- Paddle, on tick:
  - Synced up only: py = max(py-PADDLE_SPEED, 0).
  - Synced down only: py = min(py+PADDLE_SPEED, 480-PADDLE_H).
  - Both or neither pressed: no move.
  - Compute with no 10-bit underflow: compare before subtracting.
- State SERVE, on tick:
  - Ball held at the centre (316,236). Counter increments.
  - When counter==SERVE_FRAMES-1: counter clears, go to PLAY, dx=+, dy flips from its previous value.
- State PLAY, on tick, each axis evaluated independently in the same tick:
  - Right wall: dx=+ and bx+BALL_SIZE+BALL_SPEED >= 640 → bx=640-BALL_SIZE, dx=-.
  - Top wall: dy=- and by < BALL_SPEED → by=0, dy=+.
  - Bottom wall: dy=+ and by+BALL_SIZE+BALL_SPEED >= 480 → by=480-BALL_SIZE, dy=-.
  - Paddle hit: dx=- and bx <= PADDLE_X+PADDLE_W+BALL_SPEED and bx >= PADDLE_X and by+BALL_SIZE > py and by < py+PADDLE_H.
    - Result: bx=PADDLE_X+PADDLE_W, dx=+.
    - The paddle test uses py before this tick's paddle move.
  - Miss: dx=-, no paddle hit, and bx < BALL_SPEED.
    - Result: miss_count increments, saturating at 15; go to SERVE; ball goes to centre.
  - Otherwise bx/by step by ±BALL_SPEED.
- Pixel pipeline, 1-cycle latency:
  - Combinational hit tests on the current col/row, registered into rgb.
  - Colour priority: ball (6'b111111) > paddle (6'b001100) > 4-pixel border at col<4|col>=636|row<4|row>=476 (6'b010101) > background (6'b000001).
  - visible=0 forces rgb=0.
  - hsync_out/vsync_out are the 1-cycle registered copies of their inputs, so they stay aligned with rgb.
- Reset mid-frame: outputs clear immediately. The first tick after reset release starts the serve count.

Optional Feature:
- Macro `SCORE_BAR_EN`.
- Defined: pixels with row<8 && col >= 640-(miss_count*16) && miss_count!=0 render red (6'b110000).
  - Priority: above border, below ball and paddle.
  - Bar width must be computed in 10 bits.
- Undefined: no bar logic. miss_count remains an output.

Test Plan:
- Reset asserted mid-line → next cycle rgb=0, hsync_out=1, vsync_out=1, miss_count=0; one cycle after release, pixel (316,236) pipelines out 6'b111111 once it is scanned.
- btn_up held 60 frames from py=208 → py decrements 4 per tick, clamps at 0 (paddle pixel at row 0, col 16). btn_up+btn_down together → py unchanged.
- SERVE_FRAMES=60 → ball static for 60 ticks, then bx=318 after the 61st tick.
- Ball at bx=630, dx=+ → next tick bx=632, dx=-. Ball at by=1, dy=- → by=0, dy=+.
- Paddle moved to bottom, ball travels left to bx<2 → miss_count 0→1, state SERVE, ball at (316,236). Force 16 misses → miss_count stays 15.
- Drive col/row/visible/hsync_in sequences → rgb and hsync_out equal the expected values exactly 1 cycle later; visible=0 with ball coordinates → rgb=0.
